// File: rtl/morph_pkg.sv
// Shared types and helpers for the binary morphological filter.
// Holds the mode encoding, the legal window sizes, the sync-bundle payload
// and the neutral-bit helper used to pad the window outside the image.
package morph_pkg;

  typedef enum logic {
    MODE_ERODE  = 1'b0,
    MODE_DILATE = 1'b1
  } morph_mode_e;

  localparam int unsigned KSIZE_SMALL = 3;
  localparam int unsigned KSIZE_LARGE = 5;

  // Video sync bundle carried alongside the pixel pipeline.
  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  function automatic logic ksize_legal(input int unsigned k);
    return (k == KSIZE_SMALL) || (k == KSIZE_LARGE);
  endfunction

  // Value that leaves the reduction unchanged: 1 for AND, 0 for OR.
  function automatic logic neutral_bit(input morph_mode_e m);
    return (m == MODE_ERODE);
  endfunction

endpackage

// File: rtl/binary_morph_filter_if.sv
// Video port bundle for binary_morph_filter.
// Carries mode, the incoming per_frame_* stream and the outgoing
// post_frame_* stream. With MORPH_PIXCOUNT_EN defined it also carries
// post_pix_count (width CNT_W).
// master: the side that produces input video and consumes filtered video.
// slave : the filter itself.
interface binary_morph_filter_if
`ifdef MORPH_PIXCOUNT_EN
  #(parameter int unsigned CNT_W = 19)
`endif
  ;

  logic mode;
  logic per_frame_vsync;
  logic per_frame_href;
  logic per_frame_clken;
  logic per_img_bit;
  logic post_frame_vsync;
  logic post_frame_href;
  logic post_frame_clken;
  logic post_img_bit;
`ifdef MORPH_PIXCOUNT_EN
  logic [CNT_W-1:0] post_pix_count;
`endif

  modport master (
    output mode, per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
`ifdef MORPH_PIXCOUNT_EN
    input  post_pix_count,
`endif
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );

  modport slave (
    input  mode, per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
`ifdef MORPH_PIXCOUNT_EN
    output post_pix_count,
`endif
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );

endinterface

// File: rtl/morph_line_buffer.sv
// Line delay for the morphological window.
// LINES chained shift registers of DEPTH bits, advanced on en.
// taps[0] is the pixel one line above the current one, taps[LINES-1] the
// pixel LINES lines above.
// Ports: clk, rst_n (async, active-low), en (shift strobe), din (new pixel),
//        taps (oldest bit of each line).
module morph_line_buffer #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned LINES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  output logic [LINES-1:0] taps
);

  logic [DEPTH-1:0] sr_q [LINES];

  for (genvar l = 0; l < LINES; l++) begin : g_line
    logic src_c;

    if (l == 0) begin : g_head
      assign src_c = din;
    end else begin : g_chain
      assign src_c = sr_q[l-1][DEPTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr_q[l] <= '0;
      end else if (en) begin
        sr_q[l] <= {sr_q[l][DEPTH-2:0], src_c};
      end
    end

    assign taps[l] = sr_q[l][DEPTH-1];
  end

endmodule

// File: rtl/binary_morph_filter.sv
// Binary erosion/dilation over a KSIZE x KSIZE window ending at the current
// pixel, with neutral padding outside the image and a fixed 3-clock latency.
// Ports: clk, rst_n (async, active-low), bus (binary_morph_filter_if.slave:
//        mode, per_frame_* in, post_frame_* out).
// Optional feature macro MORPH_PIXCOUNT_EN adds bus.post_pix_count, the
// number of 1 pixels output in the previous frame.
module binary_morph_filter
  import morph_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 640,
  parameter int unsigned IMG_VDISP = 480,
  parameter int unsigned KSIZE     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  binary_morph_filter_if.slave bus
);

  localparam int unsigned K     = KSIZE;
  localparam int unsigned LINES = KSIZE - 1;
  localparam int unsigned COL_W = $clog2(IMG_HDISP + 1);
  localparam int unsigned ROW_W = $clog2(IMG_VDISP + 1);
  localparam int unsigned LAT   = 3;

  if (!ksize_legal(KSIZE)) begin : g_bad_ksize
    $error("binary_morph_filter: KSIZE must be 3 or 5");
  end
  if ((IMG_HDISP < KSIZE) || (IMG_VDISP < KSIZE)) begin : g_bad_img
    $error("binary_morph_filter: image must be at least KSIZE in each dimension");
  end

  logic             vsync_d;
  logic             href_d;
  logic             accept_c;
  logic             vsync_rise_c;
  logic             href_rise_c;
  logic             href_fall_c;
  logic             write_c;
  logic             neutral_c;
  logic             erode_c;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_cur_c;
  logic [ROW_W-1:0] row_q;
  morph_mode_e      mode_q;
  logic [LINES-1:0] taps_c;
  logic [K-1:0]     col_in_c;
  logic [K-1:0][K-1:0] win_q;
  logic [K-1:0]     row_red_q;
  logic             bit_q;
  sync_t            sync_q [LAT];

  assign accept_c     = bus.per_frame_clken & bus.per_frame_href;
  assign vsync_rise_c = bus.per_frame_vsync & ~vsync_d;
  assign href_rise_c  = bus.per_frame_href & ~href_d;
  assign href_fall_c  = ~bus.per_frame_href & href_d;
  // The first pixel of a line can arrive on the href rising edge itself.
  assign col_cur_c    = href_rise_c ? '0 : col_q;
  assign write_c      = accept_c & (col_cur_c < COL_W'(IMG_HDISP));
  assign neutral_c    = neutral_bit(mode_q);
  assign erode_c      = (mode_q == MODE_ERODE);

  // Edge detectors for vsync/href.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
    end else begin
      vsync_d <= bus.per_frame_vsync;
      href_d  <= bus.per_frame_href;
    end
  end

  // Column position of the next accepted pixel, saturating at IMG_HDISP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
    end else if (accept_c) begin
      col_q <= (col_cur_c == COL_W'(IMG_HDISP)) ? col_cur_c : col_cur_c + COL_W'(1);
    end else if (href_rise_c) begin
      col_q <= '0;
    end
  end

  // Row index within the frame; vsync clear takes priority over href fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
    end else if (vsync_rise_c) begin
      row_q <= '0;
    end else if (href_fall_c && (row_q != ROW_W'(IMG_VDISP))) begin
      row_q <= row_q + ROW_W'(1);
    end
  end

  // Mode is frozen for the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_ERODE;
    end else if (vsync_rise_c) begin
      mode_q <= morph_mode_e'(bus.mode);
    end
  end

  morph_line_buffer #(
    .DEPTH (IMG_HDISP),
    .LINES (LINES)
  ) u_line_buffer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (write_c),
    .din   (bus.per_img_bit),
    .taps  (taps_c)
  );

  // New window column: row K-1 is the live pixel, row r sits K-1-r lines
  // above it and is padded while that line lies above the frame top.
  for (genvar r = 0; r < K; r++) begin : g_col
    if (r == K - 1) begin : g_cur
      assign col_in_c[r] = bus.per_img_bit;
    end else begin : g_tap
      assign col_in_c[r] = (row_q < ROW_W'(K - 1 - r)) ? neutral_c : taps_c[K-2-r];
    end
  end

  // Stage 0: window shift. At column 0 the older columns lie left of the
  // image, so they are refilled with the neutral value instead of stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else if (accept_c) begin
      for (int r = 0; r < K; r++) begin
        win_q[r] <= {col_in_c[r], (col_cur_c == '0) ? {(K-1){neutral_c}} : win_q[r][K-1:1]};
      end
    end
  end

  // Stages 1 and 2: per-row reduction, then reduction across rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_red_q <= '0;
      bit_q     <= 1'b0;
    end else begin
      for (int r = 0; r < K; r++) begin
        row_red_q[r] <= erode_c ? (&win_q[r]) : (|win_q[r]);
      end
      bit_q <= (erode_c ? (&row_red_q) : (|row_red_q)) & sync_q[LAT-2].href;
    end
  end

  // Sync delay matched to the pixel pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= {bus.per_frame_vsync, bus.per_frame_href, bus.per_frame_clken};
      for (int i = 1; i < LAT; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign bus.post_frame_vsync = sync_q[LAT-1].vsync;
  assign bus.post_frame_href  = sync_q[LAT-1].href;
  assign bus.post_frame_clken = sync_q[LAT-1].clken;
  assign bus.post_img_bit     = bit_q;

`ifdef MORPH_PIXCOUNT_EN
  localparam int unsigned CNT_W = $clog2(IMG_HDISP * IMG_VDISP + 1);

  logic             post_vsync_d;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  // Count output 1s per frame; publish and restart on output vsync rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vsync_d <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
    end else begin
      post_vsync_d <= sync_q[LAT-1].vsync;
      if (sync_q[LAT-1].vsync && !post_vsync_d) begin
        cnt_q <= acc_q;
        acc_q <= '0;
      end else if (sync_q[LAT-1].clken && sync_q[LAT-1].href && bit_q) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end

  assign bus.post_pix_count = cnt_q;
`endif

endmodule

// File: tb/tb_binary_morph_filter.sv
// Self-checking bench: 8x8 frames into a KSIZE=3 and a KSIZE=5 filter in
// parallel, compared against a direct window-reduction model of the image.
module tb_binary_morph_filter;

  localparam int unsigned H    = 8;
  localparam int unsigned V    = 8;
  localparam int unsigned NPIX = H * V;
`ifdef MORPH_PIXCOUNT_EN
  localparam int unsigned CNT_W = $clog2(H * V + 1);
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0, hr = 1'b0, ce = 1'b0, px = 1'b0, md = 1'b0;

  int checks = 0;
  int errors = 0;

  bit img [V][H];
  bit q3[$];
  bit q5[$];
  int cyc = 0;
  int in_first = 0, out_first = 0, leak = 0;
  bit got_in = 0, got_out = 0;
  int frame_id = 0, mon_id = 0;
  int prev3 = 0, prev5 = 0;
  bit prev_valid = 1'b1;

  always #5 clk = ~clk;

  binary_morph_filter_if
`ifdef MORPH_PIXCOUNT_EN
    #(.CNT_W(CNT_W))
`endif
    if3 ();

  binary_morph_filter_if
`ifdef MORPH_PIXCOUNT_EN
    #(.CNT_W(CNT_W))
`endif
    if5 ();

  assign if3.mode = md;
  assign if3.per_frame_vsync = vs;
  assign if3.per_frame_href  = hr;
  assign if3.per_frame_clken = ce;
  assign if3.per_img_bit     = px;
  assign if5.mode = md;
  assign if5.per_frame_vsync = vs;
  assign if5.per_frame_href  = hr;
  assign if5.per_frame_clken = ce;
  assign if5.per_img_bit     = px;

  binary_morph_filter #(.IMG_HDISP(H), .IMG_VDISP(V), .KSIZE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));
  binary_morph_filter #(.IMG_HDISP(H), .IMG_VDISP(V), .KSIZE(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .bus(if5.slave));

  always @(posedge clk) cyc <= cyc + 1;

  // Output collector; restarts whenever a new frame is announced.
  always @(negedge clk) begin
    if (frame_id != mon_id) begin
      mon_id = frame_id;
      q3.delete();
      q5.delete();
      leak = 0;
      got_in = 0;
      got_out = 0;
    end
    if (if3.post_frame_clken && if3.post_frame_href) q3.push_back(if3.post_img_bit);
    if (if5.post_frame_clken && if5.post_frame_href) q5.push_back(if5.post_img_bit);
    if (!if3.post_frame_href && if3.post_img_bit) leak++;
    if (!if5.post_frame_href && if5.post_img_bit) leak++;
    if (!got_in && ce && hr) begin got_in = 1; in_first = cyc; end
    if (!got_out && if3.post_frame_clken && if3.post_frame_href) begin
      got_out = 1; out_first = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic v, input logic h, input logic c, input logic p);
    @(posedge clk);
    #1;
    vs = v; hr = h; ce = c; px = p;
  endtask

  // Reduction of the K x K neighbourhood ending at (r,c); outside = neutral.
  function automatic bit model(input bit m, input int k, input int r, input int c);
    bit acc;
    acc = ~m;
    for (int dr = 0; dr < k; dr++) begin
      for (int dc = 0; dc < k; dc++) begin
        int rr;
        int cc;
        bit b;
        rr = r - dr;
        cc = c - dc;
        b = (rr < 0 || cc < 0) ? ~m : img[rr][cc];
        acc = m ? (acc | b) : (acc & b);
      end
    end
    return acc;
  endfunction

  task automatic fill_random(input bit m);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = m ? ($urandom_range(0, 99) < 12) : ($urandom_range(0, 99) < 88);
  endtask

  task automatic fill_const(input bit b);
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        img[r][c] = b;
  endtask

  // Frame start: vsync pulse, output-vsync latency and previous-frame count.
  task automatic vsync_phase();
    int seen;
    seen = -1;
    frame_id++;
    for (int i = 0; i < 8; i++) begin
      tick(i < 4, 1'b0, 1'b0, 1'b0);
      if (seen >= 0 && i == seen + 1 && prev_valid) begin
`ifdef MORPH_PIXCOUNT_EN
        chk("pixcount3", 32'(if3.post_pix_count), 32'(prev3));
        chk("pixcount5", 32'(if5.post_pix_count), 32'(prev5));
`endif
      end
      if (seen < 0 && if3.post_frame_vsync) seen = i;
    end
    chk("vsync_latency", 32'(seen), 32'd3);
  endtask

  task automatic check_frame(input bit m);
    int n3;
    int n5;
    n3 = 0;
    n5 = 0;
    chk("len3", 32'(q3.size()), 32'(NPIX));
    chk("len5", 32'(q5.size()), 32'(NPIX));
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        int idx;
        bit e3;
        bit e5;
        idx = r * H + c;
        e3 = model(m, 3, r, c);
        e5 = model(m, 5, r, c);
        n3 += int'(e3);
        n5 += int'(e5);
        if (idx < q3.size()) chk($sformatf("k3_r%0d_c%0d", r, c), 32'(q3[idx]), 32'(e3));
        if (idx < q5.size()) chk($sformatf("k5_r%0d_c%0d", r, c), 32'(q5[idx]), 32'(e5));
      end
    end
    chk("pix_latency", got_out ? 32'(out_first - in_first) : 32'hFFFF_FFFF, 32'd3);
    prev3 = n3;
    prev5 = n5;
    prev_valid = 1'b1;
  endtask

  // One frame of img with random clken gaps and stray clken between lines.
  task automatic run_frame(input bit m, input bit toggle, input int rst_row, input bit check);
    md = m;
    vsync_phase();
    for (int r = 0; r < V; r++) begin
      int c;
      if (toggle && r == 4) md = ~m;
      c = 0;
      while (c < H) begin
        if (r == rst_row && c == H / 2) begin
          @(posedge clk);
          #1;
          rst_n = 1'b0;
          #1;
          chk("rst_async3", 32'({if3.post_frame_vsync, if3.post_frame_href,
                                if3.post_frame_clken, if3.post_img_bit}), 32'd0);
          chk("rst_async5", 32'({if5.post_frame_vsync, if5.post_frame_href,
                                if5.post_frame_clken, if5.post_img_bit}), 32'd0);
          @(posedge clk);
          #1;
          chk("rst_hold3", 32'({if3.post_frame_href, if3.post_frame_clken, if3.post_img_bit}), 32'd0);
`ifdef MORPH_PIXCOUNT_EN
          chk("rst_pixcount3", 32'(if3.post_pix_count), 32'd0);
`endif
          rst_n = 1'b1;
        end
        if ($urandom_range(0, 3) == 0) begin
          tick(1'b0, 1'b1, 1'b0, 1'($urandom));
        end else begin
          tick(1'b0, 1'b1, 1'b1, img[r][c]);
          c++;
        end
      end
      repeat (3) tick(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    end
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
    if (check) check_frame(m);
    else prev_valid = 1'b0;
    chk("bit_outside_href", 32'(leak), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({if3.post_frame_vsync, if3.post_frame_href, if3.post_frame_clken,
                              if3.post_img_bit, if5.post_frame_href, if5.post_img_bit}), 32'd0);
    rst_n = 1'b1;

    // All-ones erosion: every output 1 for both window sizes.
    fill_const(1'b1);
    run_frame(1'b0, 1'b0, -1, 1'b1);

    // Single 1 at (2,3): 3x3 block for dilation, nothing for erosion.
    fill_const(1'b0);
    img[2][3] = 1'b1;
    run_frame(1'b1, 1'b0, -1, 1'b1);
    run_frame(1'b0, 1'b0, -1, 1'b1);

    // 5x5 block of 1s at rows/cols 1..5 under erosion.
    fill_const(1'b0);
    for (int r = 1; r <= 5; r++)
      for (int c = 1; c <= 5; c++)
        img[r][c] = 1'b1;
    run_frame(1'b0, 1'b0, -1, 1'b1);

    // Mode toggled mid-frame only affects the following frame.
    fill_random(1'b0);
    run_frame(1'b0, 1'b1, -1, 1'b1);
    fill_random(1'b1);
    run_frame(1'b1, 1'b0, -1, 1'b1);

    // Reset in the middle of row 3, then a clean frame.
    fill_random(1'b1);
    run_frame(1'b1, 1'b0, 3, 1'b0);
    fill_random(1'b0);
    run_frame(1'b0, 1'b0, -1, 1'b1);

    // Random frames with random mode.
    for (int f = 0; f < 4; f++) begin
      bit m;
      m = 1'($urandom);
      fill_random(m);
      run_frame(m, 1'b0, -1, 1'b1);
    end

    // Trailing vsync publishes the last frame's count.
    vsync_phase();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_morph_filter.md
# binary_morph_filter

Parametrised 1-bit morphological filter for the binary video path: performs erosion or dilation over a KSIZE×KSIZE square window, with run-time mode selection and image-border handling. It sits after binarisation and before region or centroid logic. It contains its own line buffers and carries vsync/href/clken through with fixed latency.

## Interface
- IMG_HDISP, 640, active pixels per line (≥ KSIZE)
- IMG_VDISP, 480, active lines per frame (≥ KSIZE)
- KSIZE, 3, window size; legal values 3 or 5; elaboration error otherwise
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- mode  in  1  0 = erosion (AND), 1 = dilation (OR); sampled at frame start
- per_frame_vsync  in  1  input vsync
- per_frame_href  in  1  input line valid
- per_frame_clken  in  1  input pixel strobe
- per_img_bit  in  1  input pixel
- post_frame_vsync  out  1  output vsync
- post_frame_href  out  1  output line valid
- post_frame_clken  out  1  output pixel strobe
- post_img_bit  out  1  filtered pixel; forced 0 while post_frame_href = 0

## Operation
- A pixel is accepted only when per_frame_clken and per_frame_href are both 1; clken outside href is ignored.
- col counter: cleared on href rising edge; +1 per accepted pixel; saturates at IMG_HDISP. Pixels with col ≥ IMG_HDISP are not written.
- row counter: cleared on vsync rising edge; +1 on href falling edge; saturates at IMG_VDISP.
- mode_q latches mode on the vsync rising edge. Mid-frame changes to mode take effect from the next frame only.
- Line buffers: KSIZE-1 lines of IMG_HDISP bits, written/shifted on each accepted pixel.
- Window: a KSIZE×KSIZE register shifts one column per accepted pixel. The column is formed from the line-buffer taps plus the current pixel.
- Window position: the window ends at the current pixel (rows r-K+1..r, cols c-K+1..c, K = KSIZE). The output image is therefore offset by (K-1)/2 rows and columns; downstream compensates.
- Border rule: a window position with row < 0 or col < 0 is replaced by the neutral value of mode_q (1 for erosion, 0 for dilation). Stale buffer contents from the previous frame/line never reach the result.
- Result: erosion = AND of all K² bits; dilation = OR of all K² bits.

## Timing
- Latency 3 clk, identical for all four outputs.
  - Stage 0: window register capture.
  - Stage 1: per-row reduction of K bits, registered.
  - Stage 2: reduction of K row results, registered.
- post_frame_vsync/href/clken = per_frame_* delayed exactly 3 clk via shift registers.
- post_img_bit is valid on cycles where post_frame_clken & post_frame_href = 1.
- Reset: all outputs, counters, mode_q (=0), pipeline registers and window are 0 asynchronously. Line-buffer contents need not be cleared, because the border rule masks them.
- Reset mid-frame: outputs go 0 immediately. The remainder of that frame is undefined but bounded (post_img_bit = 0 outside href). The first full frame after the next vsync rising edge is correct.
- Simultaneous vsync rising edge and href falling edge: the vsync clear wins.

## Configuration
- MORPH_PIXCOUNT_EN defined:
  - Adds output post_pix_count, width $clog2(IMG_HDISP*IMG_VDISP+1), reset 0.
  - An accumulator counts cycles where post_frame_clken & post_frame_href & post_img_bit.
  - On the post_frame_vsync rising edge, the accumulator value is copied to post_pix_count and the accumulator is cleared in the same cycle.
- MORPH_PIXCOUNT_EN undefined: the port and the logic are absent; behaviour is otherwise identical.

## Structure
- morph_pkg holds:
  - MODE_ERODE = 1'b0, MODE_DILATE = 1'b1
  - the legal KSIZE values
  - the function returning the neutral bit for a mode
- Sub-module morph_line_buffer:
  - parameters DEPTH = IMG_HDISP, LINES = KSIZE-1
  - inputs: clk, rst_n, en, din
  - output: taps[LINES-1:0]
  - implemented as a shift register or dual-port RAM; synthesiser choice.
- The top level holds the counters, mode latch, window, reduction pipeline, sync delay and optional counter.

## Test plan
- IMG 8×8, KSIZE=3, erosion, all-ones frame → all 64 outputs 1; first post_frame_clken exactly 3 clk after first input clken.
- IMG 8×8, KSIZE=3, single 1 at (2,3):
  - dilation → 1s exactly at rows 2..4 × cols 3..5 (9 pixels);
  - erosion → all 0.
- IMG 8×8, KSIZE=5, erosion, 1s at rows 1..5 × cols 1..5 → single output 1 at (5,5), all others 0.
- mode toggled 0→1 at row 4 of frame N → frame N fully eroded; frame N+1 fully dilated.
- rst_n pulsed low at row 3 → all outputs 0 during reset; next frame bit-exact against the reference model.
- MORPH_PIXCOUNT_EN, IMG 8×8, dilation, single 1 at (2,3) → post_pix_count = 9 one cycle after the following post_frame_vsync rising edge.
